// File: rtl/ad9643_axi_pkg.sv
// Shared types and constants for the AD9643 AXI-Lite control path.
// FSM states, AXI response codes, register offsets and CTRL bit positions.
package ad9643_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_AW_W,
    ST_WR_B,
    ST_RD_AR,
    ST_RD_R,
    ST_RSP
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT = 3'b000;

  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;

  localparam int CTRL_DATA_EN   = 0;
  localparam int CTRL_DELAY_RST = 1;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: one command in, one AXI-Lite transaction out.
// Ports: cmd_* request, rsp_* response, timeout flag, m_axi_* master bus.
module axi_lite_master
  import ad9643_axi_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]                    cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]                    m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT_CYCLES);

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [CW-1:0]   wd_q, wd_d;
  logic            cmd_ready_d, rsp_valid_d, timeout_d;
  logic            awvalid_d, wvalid_d, arvalid_d;
  logic            bready_d, rready_d;
  logic [DW-1:0]   rsp_rdata_d;
  logic [1:0]      rsp_resp_d;

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign m_axi_awprot = AXI_PROT;
  assign m_axi_arprot = AXI_PROT;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wd_d        = wd_q;
    awvalid_d   = m_axi_awvalid;
    wvalid_d    = m_axi_wvalid;
    arvalid_d   = m_axi_arvalid;
    bready_d    = m_axi_bready;
    rready_d    = m_axi_rready;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_resp_d  = rsp_resp;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          wd_d    = '0;
          if (cmd_write) begin
            state_d   = ST_WR_AW_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WR_AW_W: begin
        // AW and W retire independently; leave once both are done
        if (m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = ST_WR_B;
          bready_d = 1'b1;
        end
      end
      ST_WR_B: begin
        if (m_axi_bvalid) begin
          state_d     = ST_RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi_bresp;
        end
      end
      ST_RD_AR: begin
        if (m_axi_arready) begin
          state_d   = ST_RD_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      ST_RD_R: begin
        if (m_axi_rvalid) begin
          state_d     = ST_RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // watchdog runs only while waiting on the slave
    if (state_q inside {ST_WR_AW_W, ST_WR_B, ST_RD_AR, ST_RD_R}
        && wd_q != WD_MAX)
      wd_d = wd_q + 1'b1;
    timeout_d   = timeout | (wd_d == WD_MAX);
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      wd_q          <= '0;
      cmd_ready     <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      timeout       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      wd_q          <= wd_d;
      cmd_ready     <= cmd_ready_d;
      m_axi_awvalid <= awvalid_d;
      m_axi_wvalid  <= wvalid_d;
      m_axi_arvalid <= arvalid_d;
      m_axi_bready  <= bready_d;
      m_axi_rready  <= rready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_rdata     <= rsp_rdata_d;
      rsp_resp      <= rsp_resp_d;
      timeout       <= timeout_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: ADC control register slave, bus monitor,
// and a register-map reference model driven by random commands.
module tb_axi_lite_master;
  import ad9643_axi_pkg::*;

  localparam logic [3:0] REG_SCRATCH = 4'h8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [3:0]  cmd_addr = '0, cmd_wstrb = '0;
  logic [31:0] cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, timeout;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;

  int compared = 0;
  int mism = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_lite_master #(
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ADDR_WIDTH(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .timeout(timeout),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  // ---------------- slave: CTRL / STATUS / SCRATCH, 0xC undecoded
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic aw_have, w_have, ar_have;
  logic [3:0] s_awaddr, s_araddr, s_wstrb;
  logic [31:0] s_wdata, s_scratch;
  logic s_en, s_drst;
  logic adc_or = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready <= 0; wready <= 0; bvalid <= 0; arready <= 0; rvalid <= 0;
      aw_have <= 0; w_have <= 0; ar_have <= 0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      s_awaddr <= 0; s_araddr <= 0; s_wstrb <= 0; s_wdata <= 0;
      s_scratch <= 0; s_en <= 0; s_drst <= 0;
      bresp <= 0; rresp <= 0; rdata <= 0;
    end else begin
      awready <= 0; wready <= 0; arready <= 0;
      if (awvalid && awready) begin
        aw_have <= 1; s_awaddr <= awaddr; aw_cnt <= 0;
      end else if (awvalid && !aw_have) begin
        if (aw_cnt >= aw_dly) awready <= 1; else aw_cnt <= aw_cnt + 1;
      end
      if (wvalid && wready) begin
        w_have <= 1; s_wdata <= wdata; s_wstrb <= wstrb; w_cnt <= 0;
      end else if (wvalid && !w_have) begin
        if (w_cnt >= w_dly) wready <= 1; else w_cnt <= w_cnt + 1;
      end
      if (bvalid && bready) begin
        bvalid <= 0; aw_have <= 0; w_have <= 0; b_cnt <= 0;
      end else if (aw_have && w_have && !bvalid) begin
        if (b_cnt >= b_dly) begin
          bvalid <= 1;
          case (s_awaddr)
            4'h0: begin
              bresp <= 2'b00;
              if (s_wstrb[0]) begin s_en <= s_wdata[0]; s_drst <= s_wdata[1]; end
            end
            4'h4: bresp <= 2'b10;
            4'h8: begin
              bresp <= 2'b00;
              for (int b = 0; b < 4; b++)
                if (s_wstrb[b]) s_scratch[8*b +: 8] <= s_wdata[8*b +: 8];
            end
            default: bresp <= 2'b11;
          endcase
        end else b_cnt <= b_cnt + 1;
      end
      if (arvalid && arready) begin
        ar_have <= 1; s_araddr <= araddr; ar_cnt <= 0;
      end else if (arvalid && !ar_have) begin
        if (ar_cnt >= ar_dly) arready <= 1; else ar_cnt <= ar_cnt + 1;
      end
      if (rvalid && rready) begin
        rvalid <= 0; ar_have <= 0; r_cnt <= 0;
      end else if (ar_have && !rvalid) begin
        if (r_cnt >= r_dly) begin
          rvalid <= 1;
          case (s_araddr)
            4'h0: begin rdata <= {30'b0, s_drst, s_en}; rresp <= 2'b00; end
            4'h4: begin rdata <= {31'b0, adc_or}; rresp <= 2'b00; end
            4'h8: begin rdata <= s_scratch; rresp <= 2'b00; end
            default: begin rdata <= 32'h0; rresp <= 2'b11; end
          endcase
        end else r_cnt <= r_cnt + 1;
      end
    end
  end

  // ---------------- monitor: handshake counts and AXI stability rules
  int aw_hs = 0, w_hs = 0, split = 0;
  int viol_aw = 0, viol_w = 0, viol_ar = 0;
  int acc_n = 0, last_acc = 0, gap = 0;
  logic p_awv = 0, p_awhs = 0, p_wv = 0, p_whs = 0, p_arv = 0, p_arhs = 0;
  logic [3:0] p_awa, p_ara, p_ws;
  logic [31:0] p_wd;

  always @(posedge clk) begin
    if (!rst_n) begin
      p_awv <= 0; p_wv <= 0; p_arv <= 0;
      p_awhs <= 0; p_whs <= 0; p_arhs <= 0;
    end else begin
      if ((p_awv && !p_awhs && (!awvalid || awaddr != p_awa)) ||
          (p_awhs && awvalid))
        viol_aw <= viol_aw + 1;
      if ((p_wv && !p_whs && (!wvalid || wdata != p_wd || wstrb != p_ws)) ||
          (p_whs && wvalid))
        viol_w <= viol_w + 1;
      if ((p_arv && !p_arhs && (!arvalid || araddr != p_ara)) ||
          (p_arhs && arvalid))
        viol_ar <= viol_ar + 1;
      if (awvalid && awready) aw_hs <= aw_hs + 1;
      if (wvalid && wready) w_hs <= w_hs + 1;
      if (awvalid && !wvalid) split <= split + 1;
      if (cmd_valid && cmd_ready) begin
        acc_n <= acc_n + 1; last_acc <= cyc; gap <= cyc - last_acc;
      end
      p_awv <= awvalid; p_awhs <= awvalid && awready; p_awa <= awaddr;
      p_wv <= wvalid; p_whs <= wvalid && wready; p_wd <= wdata; p_ws <= wstrb;
      p_arv <= arvalid; p_arhs <= arvalid && arready; p_ara <= araddr;
    end
  end

  // ---------------- reference model of the register map
  logic m_en = 0, m_drst = 0;
  logic [31:0] m_scratch = 0;

  function automatic void model(input logic wr, input logic [3:0] a,
                                input logic [31:0] d, input logic [3:0] s,
                                output logic [31:0] rd, output logic [1:0] rr);
    rd = '0;
    rr = AXI_RESP_OKAY;
    if (a == REG_CTRL) begin
      if (!wr) begin
        rd[CTRL_DATA_EN] = m_en; rd[CTRL_DELAY_RST] = m_drst;
      end else if (s[0]) begin
        m_en = d[CTRL_DATA_EN]; m_drst = d[CTRL_DELAY_RST];
      end
    end else if (a == REG_STATUS) begin
      if (wr) rr = AXI_RESP_SLVERR; else rd[0] = adc_or;
    end else if (a == REG_SCRATCH) begin
      if (!wr) rd = m_scratch;
      else for (int b = 0; b < 4; b++)
        if (s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
    end else begin
      rr = AXI_RESP_DECERR;
    end
  endfunction

  task automatic set_dly(input int a, input int w, input int b,
                         input int ar, input int r);
    aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  task automatic issue(input logic wr, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    compared++;
    if (cmd_ready !== 1'b1) begin
      mism++;
      $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(output logic [31:0] rd, output logic [1:0] rr);
    int n;
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    compared++;
    if (rsp_valid !== 1'b1) begin
      mism++;
      $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
    end
    rd = rsp_rdata;
    rr = rsp_resp;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    repeat (3) @(negedge clk);
    compared++;
    if (cmd_ready !== 1'b0) begin
      mism++; $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready);
    end
    compared++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid, timeout} !== 7'b0) begin
      mism++;
      $display("FAIL reset_outputs: got %b required 0000000",
               {awvalid, wvalid, arvalid, bready, rready, rsp_valid, timeout});
    end
    compared++;
    if ({awprot, arprot} !== 6'b0) begin
      mism++; $display("FAIL prot: got %b required 000000", {awprot, arprot});
    end
    rst_n = 1;
    @(negedge clk);
    compared++;
    if (cmd_ready !== 1'b1) begin
      mism++; $display("FAIL release_cmd_ready: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_ctrl_write();
    logic [31:0] rd, er; logic [1:0] rr, err;
    set_dly(0, 0, 0, 0, 0);
    model(1, REG_CTRL, 32'h3, 4'hF, er, err);
    issue(1, REG_CTRL, 32'h3, 4'hF);
    wait_rsp(rd, rr);
    compared++;
    if (rr !== err || rd !== er) begin
      mism++; $display("FAIL ctrl_write_rsp: got %h/%h required %h/%h", rr, rd, err, er);
    end
    compared++;
    if ({s_drst, s_en} !== 2'b11) begin
      mism++; $display("FAIL ctrl_bits: got %b required 11", {s_drst, s_en});
    end
  endtask

  task automatic test_status_read();
    logic [31:0] rd; logic [1:0] rr;
    adc_or = 1;
    issue(0, REG_STATUS, 32'h0, 4'h0);
    wait_rsp(rd, rr);
    compared++;
    if (rd !== 32'h1 || rr !== 2'b00) begin
      mism++; $display("FAIL status_read: got %h/%h required 0/00000001", rr, rd);
    end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] rd, er, d; logic [1:0] rr, err;
    int aw0, w0, sp0;
    set_dly(3, 0, 0, 0, 0);
    d = $urandom;
    aw0 = aw_hs; w0 = w_hs; sp0 = split;
    model(1, REG_SCRATCH, d, 4'hF, er, err);
    issue(1, REG_SCRATCH, d, 4'hF);
    wait_rsp(rd, rr);
    compared++;
    if (aw_hs - aw0 != 1 || w_hs - w0 != 1) begin
      mism++;
      $display("FAIL split_hs: aw %0d w %0d required 1 1", aw_hs - aw0, w_hs - w0);
    end
    // wvalid retires after its handshake while awvalid waits 3 more cycles
    compared++;
    if (split - sp0 != 3) begin
      mism++; $display("FAIL split_cycles: got %0d required 3", split - sp0);
    end
    compared++;
    if (rr !== err) begin
      mism++; $display("FAIL split_resp: got %h required %h", rr, err);
    end
    set_dly(0, 0, 0, 0, 0);
    model(0, REG_SCRATCH, 0, 0, er, err);
    issue(0, REG_SCRATCH, 0, 0);
    wait_rsp(rd, rr);
    compared++;
    if (rd !== er || rr !== err) begin
      mism++; $display("FAIL split_readback: got %h required %h", rd, er);
    end
  endtask

  task automatic test_rsp_hold();
    logic [31:0] er; logic [1:0] err;
    int n, aw0;
    set_dly(0, 0, 0, 0, 0);
    model(0, REG_CTRL, 0, 0, er, err);
    issue(0, REG_CTRL, 0, 0);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    aw0 = aw_hs;
    cmd_valid = 1; cmd_write = 1; cmd_addr = REG_SCRATCH; cmd_wdata = 32'hDEAD; cmd_wstrb = 4'hF;
    for (int i = 0; i < 10; i++) begin
      compared++;
      if ({rsp_valid, cmd_ready, rsp_rdata, rsp_resp} !== {2'b10, er, err}) begin
        mism++;
        $display("FAIL rsp_hold[%0d]: got v%b r%b %h required v1 r0 %h",
                 i, rsp_valid, cmd_ready, rsp_rdata, er);
      end
      @(negedge clk);
    end
    cmd_valid = 0;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    repeat (4) @(negedge clk);
    compared++;
    if (aw_hs != aw0 || cmd_ready !== 1'b1) begin
      mism++;
      $display("FAIL busy_cmd_ignored: writes %0d ready %b required 0 1", aw_hs - aw0, cmd_ready);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, er, d; logic [1:0] rr, err; logic [3:0] a, s; logic wr;
    for (int i = 0; i < 40; i++) begin
      set_dly($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1));
      adc_or = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a = {2'($urandom_range(0, 3)), 2'b00};
      d = $urandom;
      s = 4'($urandom);
      model(wr, a, d, s, er, err);
      issue(wr, a, d, s);
      wait_rsp(rd, rr);
      compared++;
      if (rd !== er || rr !== err) begin
        mism++;
        $display("FAIL random[%0d] wr%b a%h: got %h/%h required %h/%h",
                 i, wr, a, rr, rd, err, er);
      end
    end
    compared++;
    if (timeout !== 1'b0) begin
      mism++; $display("FAIL no_timeout: got %b required 0", timeout);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, er; logic [1:0] err;
    int n, a0;
    set_dly(0, 0, 0, 0, 0);
    d = $urandom;
    @(negedge clk);
    a0 = acc_n;
    cmd_valid = 1; cmd_write = 1; cmd_addr = REG_SCRATCH; cmd_wdata = d; cmd_wstrb = 4'hF;
    rsp_ready = 1;
    n = 0;
    while (acc_n - a0 < 3 && n < 100) begin @(negedge clk); n++; end
    cmd_valid = 0;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) model(1, REG_SCRATCH, d, 4'hF, er, err);
    compared++;
    if (acc_n - a0 != 3) begin
      mism++; $display("FAIL b2b_count: got %0d required 3", acc_n - a0);
    end
    // AW ready +1, B valid +1 beyond the master's own four cycles
    compared++;
    if (gap != 6) begin
      mism++; $display("FAIL b2b_gap: got %0d required 6", gap);
    end
    compared++;
    if (s_scratch !== m_scratch) begin
      mism++; $display("FAIL b2b_data: got %h required %h", s_scratch, m_scratch);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd, er, d; logic [1:0] rr, err;
    set_dly(0, 0, 20, 0, 0);
    d = $urandom;
    model(1, REG_SCRATCH, d, 4'hF, er, err);
    issue(1, REG_SCRATCH, d, 4'hF);
    repeat (7) @(negedge clk);
    compared++;
    if (timeout !== 1'b0) begin
      mism++; $display("FAIL timeout_early: got %b required 0 at wait 7", timeout);
    end
    @(negedge clk);
    compared++;
    if (timeout !== 1'b1) begin
      mism++; $display("FAIL timeout_set: got %b required 1 at wait 8", timeout);
    end
    wait_rsp(rd, rr);
    compared++;
    if (rr !== err || rd !== er || timeout !== 1'b1) begin
      mism++;
      $display("FAIL timeout_late_rsp: got %h/%h/%b required %h/%h/1", rr, rd, timeout, err, er);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, er; logic [1:0] rr, err;
    int n;
    set_dly(0, 0, 20, 0, 0);
    issue(1, REG_CTRL, 32'h0, 4'hF);
    n = 0;
    while (!bready && n < 50) begin @(negedge clk); n++; end
    compared++;
    if (bready !== 1'b1) begin
      mism++; $display("FAIL reach_wr_b: bready=%b required 1", bready);
    end
    #2;
    rst_n = 0;
    #1;
    compared++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready} !== 7'b0) begin
      mism++;
      $display("FAIL async_drop: got %b required 0000000",
               {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready});
    end
    repeat (2) @(negedge clk);
    m_en = 0; m_drst = 0; m_scratch = 0;
    set_dly(0, 0, 0, 0, 0);
    rst_n = 1;
    @(negedge clk);
    compared++;
    if (cmd_ready !== 1'b1 || timeout !== 1'b0) begin
      mism++;
      $display("FAIL after_reset: ready %b timeout %b required 1 0", cmd_ready, timeout);
    end
    model(0, REG_CTRL, 0, 0, er, err);
    issue(0, REG_CTRL, 0, 0);
    wait_rsp(rd, rr);
    compared++;
    if (rd !== er || rr !== err) begin
      mism++; $display("FAIL post_reset_read: got %h/%h required %h/%h", rr, rd, err, er);
    end
  endtask

  initial begin
    test_reset();
    test_ctrl_write();
    test_status_read();
    test_w_before_aw();
    test_rsp_hold();
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    compared++;
    if (viol_aw + viol_w + viol_ar != 0) begin
      mism++;
      $display("FAIL axi_stability: aw %0d w %0d ar %0d violations required 0",
               viol_aw, viol_w, viol_ar);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule
